ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter: REG_AW, 5, register-address width.
REQ-002 Parameter: CNT_W, 16, width of the stall and flush performance counters.
REQ-003 Port: clk  in  1  single clock; every flop samples on its rising edge.
REQ-004 Port: rst  in  1  reset, synchronous and active-high.
REQ-005 Port: id_valid  in  1  the ID stage holds a real instruction.
REQ-006 Port: id_rs1, id_rs2, id_rd  in  REG_AW each  register addresses decoded in ID.
REQ-007 Port: id_rs1_used, id_rs2_used  in  1 each  the instruction actually reads that source.
REQ-008 Port: id_reg_wr_en, id_alu_src, id_mem_wr_en, id_mem_rd_en, id_mem_to_reg  in  1 each  control bundle from the decoder.
REQ-009 Port: id_branch_op  in  3  branch class; 0 = BR_NONE.
REQ-010 Port: id_wb_sel  in  2  writeback select; 00 = ALU, 01 = MEM, 10 = PC+4.
REQ-011 Port: ex_redirect  in  1  the instruction in EX resolved a taken branch or jump.
REQ-012 Port: ex_*  out  bundle + rs1/rs2/rd  ID/EX control and address register outputs.
REQ-013 Port: mem_*  out  reg_wr_en, mem_wr_en, mem_rd_en, mem_to_reg, wb_sel, rd  EX/MEM register outputs.
REQ-014 Port: wb_*  out  reg_wr_en, wb_sel, rd  MEM/WB register outputs.
REQ-015 Port: stall  out  1  hold PC and the IF/ID register this cycle.
REQ-016 Port: flush_if_id  out  1  squash the IF/ID register this cycle.
REQ-017 Port: fwd_a, fwd_b  out  2 each  EX operand select; 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB result.
REQ-018 Port: stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-019 A bubble SHALL be defined as an all-zero control bundle with rd = 0.
REQ-020 Load-use hazard, combinational:
- id_valid & ex_mem_rd_en & ex_reg_wr_en & ex_rd != 0
- and (id_rs1_used & id_rs1 == ex_rd) or (id_rs2_used & id_rs2 == ex_rd).
REQ-021 While a load-use hazard is present and ex_redirect = 0:
- stall = 1
- the ID/EX register SHALL load a bubble on the next edge
- EX/MEM and MEM/WB SHALL advance normally.
REQ-022 When ex_redirect = 1:
- flush_if_id = 1 and stall = 0, regardless of any hazard
- the ID/EX register SHALL load a bubble on the next edge.
REQ-023 Otherwise, the ID/EX register SHALL load the ID bundle when id_valid = 1 and a bubble when id_valid = 0.
REQ-024 EX/MEM SHALL capture the ID/EX contents and MEM/WB SHALL capture the EX/MEM contents every cycle, with no enable.
REQ-025 fwd_a SHALL equal:
- 01 if mem_reg_wr_en & mem_rd != 0 & mem_rd == ex_rs1
- else 10 if wb_reg_wr_en & wb_rd != 0 & wb_rd == ex_rs1
- else 00.
fwd_b SHALL follow the same rules using ex_rs2. EX/MEM priority over MEM/WB is mandatory.
REQ-026 Register x0 SHALL never cause a stall or a forward.
REQ-027 Stall and flush latency: stall and flush_if_id SHALL be combinational in the same cycle as their cause, with no registered delay.
REQ-028 A load-use stall SHALL last exactly one cycle, since the bubble clears the hazard on the next cycle.
REQ-029 stall_cnt SHALL increment by 1 on every cycle with stall = 1.
REQ-030 flush_cnt SHALL increment by 1 on every cycle with flush_if_id = 1.
REQ-031 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-032 With rst = 1 at a clock edge, all of the following SHALL be bubble/zero after that edge:
- ID/EX, EX/MEM and MEM/WB registers
- stall_cnt and flush_cnt.
REQ-033 During reset, stall and flush_if_id SHALL evaluate from the bubble state, giving 0 one edge after reset asserts.
REQ-034 Reset asserted mid-stall or mid-flush SHALL abort that event; no residual stall SHALL occur after release.

Verification
REQ-035 Load-use: lw x5 in EX, then add x6,x5,x7 in ID.
- Required: stall = 1 for exactly one cycle and ex_reg_wr_en = 0 on the following cycle.
- Required: the add is then issued with fwd_a = 10.
REQ-036 Back-to-back ALU: add x3 followed by sub x4,x3,x3.
- Required: fwd_a = fwd_b = 01 and stall = 0.
REQ-037 Double producer: x3 written in both MEM and WB, consumer reads x3 in EX.
- Required: fwd_a = 01.
REQ-038 Simultaneous events: ex_redirect = 1 while a load-use hazard is present.
- Required: stall = 0 and flush_if_id = 1.
- Required: flush_cnt + 1, stall_cnt unchanged, and an ID/EX bubble on the next cycle.
REQ-039 x0: a load to x0 followed by a consumer of x0.
- Required: stall = 0 and fwd = 00.
REQ-040 Saturation and reset: force 65540 stall cycles.
- Required: stall_cnt = 16'hFFFF.
- Then assert rst for one cycle: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/ctrl_pipe_if.sv
// ctrl_pipe_if: decoded ID bundle in, pipeline control,
// hazard and forwarding status out.
interface ctrl_pipe_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              id_reg_wr_en;
    logic              id_alu_src;
    logic              id_mem_wr_en;
    logic              id_mem_rd_en;
    logic              id_mem_to_reg;
    logic [2:0]        id_branch_op;
    logic [1:0]        id_wb_sel;
    logic              ex_redirect;

    logic              ex_reg_wr_en;
    logic              ex_alu_src;
    logic              ex_mem_wr_en;
    logic              ex_mem_rd_en;
    logic              ex_mem_to_reg;
    logic [2:0]        ex_branch_op;
    logic [1:0]        ex_wb_sel;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;

    logic              mem_reg_wr_en;
    logic              mem_mem_wr_en;
    logic              mem_mem_rd_en;
    logic              mem_mem_to_reg;
    logic [1:0]        mem_wb_sel;
    logic [REG_AW-1:0] mem_rd;

    logic              wb_reg_wr_en;
    logic [1:0]        wb_wb_sel;
    logic [REG_AW-1:0] wb_rd;

    logic              stall;
    logic              flush_if_id;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd,
        output id_rs1_used, id_rs2_used,
        output id_reg_wr_en, id_alu_src, id_mem_wr_en,
        output id_mem_rd_en, id_mem_to_reg,
        output id_branch_op, id_wb_sel, ex_redirect,
        input  ex_reg_wr_en, ex_alu_src, ex_mem_wr_en,
        input  ex_mem_rd_en, ex_mem_to_reg,
        input  ex_branch_op, ex_wb_sel, ex_rs1, ex_rs2, ex_rd,
        input  mem_reg_wr_en, mem_mem_wr_en, mem_mem_rd_en,
        input  mem_mem_to_reg, mem_wb_sel, mem_rd,
        input  wb_reg_wr_en, wb_wb_sel, wb_rd,
        input  stall, flush_if_id, fwd_a, fwd_b,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd,
        input  id_rs1_used, id_rs2_used,
        input  id_reg_wr_en, id_alu_src, id_mem_wr_en,
        input  id_mem_rd_en, id_mem_to_reg,
        input  id_branch_op, id_wb_sel, ex_redirect,
        output ex_reg_wr_en, ex_alu_src, ex_mem_wr_en,
        output ex_mem_rd_en, ex_mem_to_reg,
        output ex_branch_op, ex_wb_sel, ex_rs1, ex_rs2, ex_rd,
        output mem_reg_wr_en, mem_mem_wr_en, mem_mem_rd_en,
        output mem_mem_to_reg, mem_wb_sel, mem_rd,
        output wb_reg_wr_en, wb_wb_sel, wb_rd,
        output stall, flush_if_id, fwd_a, fwd_b,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM, MEM/WB control registers with
// load-use stall, redirect flush, operand forwarding, event counters.
module ctrl_pipe #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_pipe_if.slave bus
);
    typedef struct packed {
        logic              reg_wr_en;
        logic              alu_src;
        logic              mem_wr_en;
        logic              mem_rd_en;
        logic              mem_to_reg;
        logic [2:0]        branch_op;
        logic [1:0]        wb_sel;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } id_ex_t;

    typedef struct packed {
        logic              reg_wr_en;
        logic              mem_wr_en;
        logic              mem_rd_en;
        logic              mem_to_reg;
        logic [1:0]        wb_sel;
        logic [REG_AW-1:0] rd;
    } ex_mem_t;

    typedef struct packed {
        logic              reg_wr_en;
        logic [1:0]        wb_sel;
        logic [REG_AW-1:0] rd;
    } mem_wb_t;

    id_ex_t           id_bundle;
    id_ex_t           id_ex_d;
    id_ex_t           id_ex_q;
    ex_mem_t          ex_mem_q;
    mem_wb_t          mem_wb_q;
    logic             load_use;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             stall;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    assign id_bundle = '{
        reg_wr_en:  bus.id_reg_wr_en,
        alu_src:    bus.id_alu_src,
        mem_wr_en:  bus.id_mem_wr_en,
        mem_rd_en:  bus.id_mem_rd_en,
        mem_to_reg: bus.id_mem_to_reg,
        branch_op:  bus.id_branch_op,
        wb_sel:     bus.id_wb_sel,
        rs1:        bus.id_rs1,
        rs2:        bus.id_rs2,
        rd:         bus.id_rd
    };

    // ex_rd == 0 excludes x0 from ever stalling
    assign rs1_hit  = bus.id_rs1_used && (bus.id_rs1 == id_ex_q.rd);
    assign rs2_hit  = bus.id_rs2_used && (bus.id_rs2 == id_ex_q.rd);
    assign load_use = bus.id_valid && id_ex_q.mem_rd_en
                   && id_ex_q.reg_wr_en && (id_ex_q.rd != '0)
                   && (rs1_hit || rs2_hit);

    // a redirect squashes ID anyway, so it overrides the stall
    assign flush = bus.ex_redirect;
    assign stall = load_use && !bus.ex_redirect;

    always_comb begin
        id_ex_d = '0;
        if (bus.id_valid && !load_use && !bus.ex_redirect)
            id_ex_d = id_bundle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= '{
                reg_wr_en:  id_ex_q.reg_wr_en,
                mem_wr_en:  id_ex_q.mem_wr_en,
                mem_rd_en:  id_ex_q.mem_rd_en,
                mem_to_reg: id_ex_q.mem_to_reg,
                wb_sel:     id_ex_q.wb_sel,
                rd:         id_ex_q.rd
            };
            mem_wb_q <= '{
                reg_wr_en: ex_mem_q.reg_wr_en,
                wb_sel:    ex_mem_q.wb_sel,
                rd:        ex_mem_q.rd
            };
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    // EX/MEM is the younger producer and must win
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input ex_mem_t           em,
        input mem_wb_t           mw
    );
        if (em.reg_wr_en && (em.rd != '0) && (em.rd == src))
            return 2'b01;
        if (mw.reg_wr_en && (mw.rd != '0) && (mw.rd == src))
            return 2'b10;
        return 2'b00;
    endfunction

    assign bus.fwd_a = fwd_sel(id_ex_q.rs1, ex_mem_q, mem_wb_q);
    assign bus.fwd_b = fwd_sel(id_ex_q.rs2, ex_mem_q, mem_wb_q);

    assign bus.stall       = stall;
    assign bus.flush_if_id = flush;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

    assign bus.ex_reg_wr_en  = id_ex_q.reg_wr_en;
    assign bus.ex_alu_src    = id_ex_q.alu_src;
    assign bus.ex_mem_wr_en  = id_ex_q.mem_wr_en;
    assign bus.ex_mem_rd_en  = id_ex_q.mem_rd_en;
    assign bus.ex_mem_to_reg = id_ex_q.mem_to_reg;
    assign bus.ex_branch_op  = id_ex_q.branch_op;
    assign bus.ex_wb_sel     = id_ex_q.wb_sel;
    assign bus.ex_rs1        = id_ex_q.rs1;
    assign bus.ex_rs2        = id_ex_q.rs2;
    assign bus.ex_rd         = id_ex_q.rd;

    assign bus.mem_reg_wr_en  = ex_mem_q.reg_wr_en;
    assign bus.mem_mem_wr_en  = ex_mem_q.mem_wr_en;
    assign bus.mem_mem_rd_en  = ex_mem_q.mem_rd_en;
    assign bus.mem_mem_to_reg = ex_mem_q.mem_to_reg;
    assign bus.mem_wb_sel     = ex_mem_q.wb_sel;
    assign bus.mem_rd         = ex_mem_q.rd;

    assign bus.wb_reg_wr_en = mem_wb_q.reg_wr_en;
    assign bus.wb_wb_sel    = mem_wb_q.wb_sel;
    assign bus.wb_rd        = mem_wb_q.rd;
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed vector table, multi-cycle corner cases
// and random traffic against an instruction-level pipeline model.
module tb_ctrl_pipe;
    localparam int CW   = 10;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.REG_AW(5), .CNT_W(CW)) bus ();

    ctrl_pipe #(.REG_AW(5), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // one instruction as it travels EX -> MEM -> WB
    typedef struct packed {
        logic       wr;
        logic       alu;
        logic       mwr;
        logic       mrd;
        logic       m2r;
        logic [2:0] br;
        logic [1:0] wbs;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ins_t;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       wr;
        logic       ld;
        logic       rdr;
        logic       e_st;
        logic       e_fl;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
        logic       e_exwr;
    } vec_t;

    ins_t m_pipe [3];
    int   m_sc;
    int   m_fc;
    int   tests = 0;
    int   fails = 0;

    logic       obs_stall;
    logic       obs_flush;
    logic [1:0] obs_fa;
    logic [1:0] obs_fb;
    logic       obs_exwr;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic ins_t id_ins();
        ins_t i;
        i.wr  = bus.id_reg_wr_en;
        i.alu = bus.id_alu_src;
        i.mwr = bus.id_mem_wr_en;
        i.mrd = bus.id_mem_rd_en;
        i.m2r = bus.id_mem_to_reg;
        i.br  = bus.id_branch_op;
        i.wbs = bus.id_wb_sel;
        i.rs1 = bus.id_rs1;
        i.rs2 = bus.id_rs2;
        i.rd  = bus.id_rd;
        return i;
    endfunction

    function automatic logic m_hazard();
        ins_t e;
        logic dep;
        e = m_pipe[0];
        dep = (bus.id_rs1_used && bus.id_rs1 == e.rd)
           || (bus.id_rs2_used && bus.id_rs2 == e.rd);
        return bus.id_valid && e.mrd && e.wr && e.rd != 0 && dep;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        if (m_pipe[1].wr && m_pipe[1].rd != 0 && m_pipe[1].rd == src)
            return 2'b01;
        if (m_pipe[2].wr && m_pipe[2].rd != 0 && m_pipe[2].rd == src)
            return 2'b10;
        return 2'b00;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) m_pipe[k] = '0;
        m_sc = 0;
        m_fc = 0;
    endtask

    // check at the falling edge, advance the model, settle after rise
    task automatic cycle();
        logic hz;
        logic e_st;
        logic e_fl;
        @(negedge clk);
        hz   = m_hazard();
        e_fl = bus.ex_redirect;
        e_st = hz && !bus.ex_redirect;
        obs_stall = bus.stall;
        obs_flush = bus.flush_if_id;
        obs_fa    = bus.fwd_a;
        obs_fb    = bus.fwd_b;
        obs_exwr  = bus.ex_reg_wr_en;
        chk("stall", bus.stall, e_st);
        chk("flush", bus.flush_if_id, e_fl);
        chk("fwd_a", bus.fwd_a, m_fwd(m_pipe[0].rs1));
        chk("fwd_b", bus.fwd_b, m_fwd(m_pipe[0].rs2));
        chk("ex_bundle", {bus.ex_reg_wr_en, bus.ex_alu_src,
            bus.ex_mem_wr_en, bus.ex_mem_rd_en, bus.ex_mem_to_reg,
            bus.ex_branch_op, bus.ex_wb_sel, bus.ex_rs1, bus.ex_rs2,
            bus.ex_rd}, m_pipe[0]);
        chk("mem_bundle", {bus.mem_reg_wr_en, bus.mem_mem_wr_en,
            bus.mem_mem_rd_en, bus.mem_mem_to_reg, bus.mem_wb_sel,
            bus.mem_rd}, {m_pipe[1].wr, m_pipe[1].mwr, m_pipe[1].mrd,
            m_pipe[1].m2r, m_pipe[1].wbs, m_pipe[1].rd});
        chk("wb_bundle", {bus.wb_reg_wr_en, bus.wb_wb_sel, bus.wb_rd},
            {m_pipe[2].wr, m_pipe[2].wbs, m_pipe[2].rd});
        chk("stall_cnt", bus.stall_cnt, m_sc);
        chk("flush_cnt", bus.flush_cnt, m_fc);
        if (rst) begin
            m_reset();
        end else begin
            if (e_st && m_sc < CMAX) m_sc++;
            if (e_fl && m_fc < CMAX) m_fc++;
            m_pipe[2] = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = (bus.id_valid && !e_fl && !hz) ? id_ins() : '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int rs1, input int rs2,
                         input int rd, input logic u1, input logic u2,
                         input logic wr, input logic ld,
                         input logic rdr);
        bus.id_valid      = v;
        bus.id_rs1        = 5'(rs1);
        bus.id_rs2        = 5'(rs2);
        bus.id_rd         = 5'(rd);
        bus.id_rs1_used   = u1;
        bus.id_rs2_used   = u2;
        bus.id_reg_wr_en  = wr;
        bus.id_alu_src    = 1'b0;
        bus.id_mem_wr_en  = 1'b0;
        bus.id_mem_rd_en  = ld;
        bus.id_mem_to_reg = ld;
        bus.id_branch_op  = 3'd0;
        bus.id_wb_sel     = ld ? 2'b01 : 2'b00;
        bus.ex_redirect   = rdr;
    endtask

    function automatic vec_t mk(input logic v, input int rs1,
        input int rs2, input int rd, input logic u1, input logic u2,
        input logic wr, input logic ld, input logic rdr,
        input logic st, input logic fl, input int fa, input int fb,
        input logic exwr);
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.rd = 5'(rd);
        r.u1 = u1; r.u2 = u2; r.wr = wr; r.ld = ld; r.rdr = rdr;
        r.e_st = st; r.e_fl = fl; r.e_fa = 2'(fa); r.e_fb = 2'(fb);
        r.e_exwr = exwr;
        return r;
    endfunction

    vec_t tbl [17];

    initial begin
        // load-use: lw x5, add x6,x5,x7 stalls once then gets WB fwd
        tbl[0]  = mk(1, 1, 0, 5, 1, 0, 1, 1, 0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 5, 7, 6, 1, 1, 1, 0, 0,  1, 0, 0, 0, 1);
        tbl[2]  = mk(1, 5, 7, 6, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 2, 0, 1);
        // back-to-back ALU: add x3; sub x4,x3,x3
        tbl[4]  = mk(1, 1, 2, 3, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        tbl[5]  = mk(1, 3, 3, 4, 1, 1, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1);
        // x3 in both MEM and WB
        tbl[7]  = mk(1, 1, 2, 3, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 1, 2, 3, 1, 1, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[9]  = mk(1, 3, 0, 7, 1, 1, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1);
        // redirect coinciding with a load-use hazard
        tbl[11] = mk(1, 1, 0, 5, 1, 0, 1, 1, 0,  0, 0, 0, 0, 0);
        tbl[12] = mk(1, 5, 7, 6, 1, 1, 1, 0, 1,  0, 1, 0, 0, 1);
        // load to x0, then consumer of x0
        tbl[13] = mk(1, 1, 0, 0, 1, 0, 1, 1, 0,  0, 0, 0, 0, 0);
        tbl[14] = mk(1, 0, 0, 6, 1, 1, 1, 0, 0,  0, 0, 0, 0, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        chk("reset_state", {bus.ex_reg_wr_en, bus.ex_mem_rd_en,
            bus.ex_rd, bus.mem_reg_wr_en, bus.mem_rd,
            bus.wb_reg_wr_en, bus.wb_rd, bus.stall_cnt,
            bus.flush_cnt, bus.fwd_a, bus.fwd_b}, 64'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                  tbl[i].u1, tbl[i].u2, tbl[i].wr, tbl[i].ld,
                  tbl[i].rdr);
            cycle();
            chk($sformatf("vec%0d_stall", i), obs_stall, tbl[i].e_st);
            chk($sformatf("vec%0d_flush", i), obs_flush, tbl[i].e_fl);
            chk($sformatf("vec%0d_fwd", i), {obs_fa, obs_fb},
                {tbl[i].e_fa, tbl[i].e_fb});
            chk($sformatf("vec%0d_exwr", i), obs_exwr, tbl[i].e_exwr);
        end
        chk("vec_stall_cnt", bus.stall_cnt, 1);
        chk("vec_flush_cnt", bus.flush_cnt, 1);

        // stall counter saturation: one stall per lw/consumer pair
        for (int i = 0; i < CMAX + 5; i++) begin
            drive(1, 1, 0, 5, 1, 0, 1, 1, 0);
            cycle();
            drive(1, 5, 7, 6, 1, 1, 1, 0, 0);
            cycle();
        end
        chk("stall_sat", bus.stall_cnt, CMAX);

        for (int i = 0; i < CMAX + 5; i++) begin
            drive(1, 2, 3, 4, 1, 1, 1, 0, 1);
            cycle();
        end
        chk("flush_sat", bus.flush_cnt, CMAX);
        chk("stall_hold", bus.stall_cnt, CMAX);

        // reset landing on a stall cycle aborts it
        drive(1, 1, 0, 5, 1, 0, 1, 1, 0);
        cycle();
        drive(1, 5, 7, 6, 1, 1, 1, 0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_mid_stall_seen", obs_stall, 1'b1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_all_zero", {bus.ex_reg_wr_en, bus.ex_mem_rd_en,
            bus.ex_rd, bus.ex_rs1, bus.mem_reg_wr_en, bus.mem_rd,
            bus.wb_reg_wr_en, bus.wb_rd, bus.stall, bus.flush_if_id,
            bus.fwd_a, bus.fwd_b, bus.stall_cnt, bus.flush_cnt}, 64'd0);
        drive(1, 5, 7, 6, 1, 1, 1, 0, 0);
        cycle();
        chk("no_residual_stall", obs_stall, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            bus.id_valid      = ($urandom_range(0, 3) != 0);
            bus.id_rs1        = 5'($urandom_range(0, 3));
            bus.id_rs2        = 5'($urandom_range(0, 3));
            bus.id_rd         = 5'($urandom_range(0, 3));
            bus.id_rs1_used   = 1'($urandom_range(0, 1));
            bus.id_rs2_used   = 1'($urandom_range(0, 1));
            bus.id_reg_wr_en  = ($urandom_range(0, 3) != 0);
            bus.id_alu_src    = 1'($urandom_range(0, 1));
            bus.id_mem_wr_en  = 1'($urandom_range(0, 1));
            bus.id_mem_rd_en  = 1'($urandom_range(0, 1));
            bus.id_mem_to_reg = 1'($urandom_range(0, 1));
            bus.id_branch_op  = 3'($urandom_range(0, 7));
            bus.id_wb_sel     = 2'($urandom_range(0, 2));
            bus.ex_redirect   = ($urandom_range(0, 9) == 0);
            rst               = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
